seg_hud_driver: RTL and testbench
=================================

Name: seg_hud_driver

Overview:
Heads-up display driver for the game board's 4-digit seven-segment display. It takes the game core's score, lives and game-over status and time-multiplexes them onto abcdefgh/digit. It sits directly downstream of the game core and replaces the free-running per-clock digit mux in the board top.
Features: a real scan rate, leading-zero blanking, a sequential binary-to-BCD converter, a life-lost blink and an "End" screen.

Parameters:
- clk_mhz, 50: system clock frequency in MHz.
- refresh_hz, 1000: per-digit dwell rate. Dwell = clk_mhz*1_000_000/refresh_hz cycles, which must be at least 8.
- blink_hz, 4: blink frequency. Half-period = clk_mhz*1_000_000/(2*blink_hz) cycles.
- blink_toggles, 8: number of half-periods in one life-lost blink sequence.
- w_score, 7: score width. Values above 99 saturate to 99.
- w_lifes, 3: lives width. Displayed value range is 0..7.
- w_digit, 4: number of digits. Fixed at 4; any other value is a compile-time error.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- score, input, w_score: current score, binary.
- n_lifes, input, w_lifes: remaining lives, binary.
- life_lost, input, 1: single-cycle pulse from the game core.
- game_over, input, 1: level signal, high while the game is over.
- abcdefgh, output, 8: segments, active-high. Bit 7 = a ... bit 1 = g, bit 0 = h (dp). Registered.
- digit, output, w_digit: one-hot digit enable, active-high. 4'b1000 = leftmost. Registered.

Behaviour:
- Reset (rst high at a clk edge):
  - abcdefgh = 0, digit = 0.
  - scan index = 0, dwell counter = 0.
  - BCD register = 0 (tens 0, ones 0); converter idle.
  - FSM = NORMAL; blink counters = 0; last captured score = 0.
  - rst mid-conversion or mid-blink aborts it with no residual state.
- Scan:
  - The dwell counter counts 0..dwell-1. At terminal count it pulses tick.
  - On tick: scan index increments 0→1→2→3→0 (wraps), and digit/abcdefgh load the pattern for the new index on the same edge.
  - Outputs therefore change exactly once per dwell. The first non-zero digit appears `dwell` cycles after reset release, with index 1 = 4'b0100.
- Index-to-digit map: 0 → 4'b1000, 1 → 4'b0100, 2 → 4'b0010, 3 → 4'b0001.
- NORMAL content:
  - Index 0: 'L'.
  - Index 1: lives digit.
  - Index 2: score tens. Blank when tens = 0.
  - Index 3: score ones. Always shown.
- BCD conversion:
  - The saturated score (min(score, 99)) is compared each cycle with the last captured value. When they differ and the converter is idle, capture the value and start.
  - Shift-add-3 runs one bit per cycle. Done is 7 cycles after start; the BCD register is written on the done cycle.
  - The display shows the old BCD until done.
  - A score change during conversion is ignored until done. It is then detected by the compare and converted next, so the converter never loses the final value.
- FSM states: NORMAL, BLINK, OVER.
  - NORMAL → BLINK on life_lost. Load blink toggle count = blink_toggles and half-period counter = 0; phase = off.
  - BLINK: the lives digit is blanked while phase = off and shown while phase = on. Phase toggles every half-period. After blink_toggles toggles → NORMAL.
  - life_lost while in BLINK restarts the sequence.
  - Any state → OVER when game_over = 1. This has priority over a simultaneous life_lost.
  - OVER content: index 0 'E', 1 'n', 2 'd', 3 blank. Score and lives are not shown.
  - OVER → NORMAL when game_over = 0. Blink state is cleared.
- Encodings:
  - 0 = FC, 1 = 60, 2 = DA, 3 = F2, 4 = 66, 5 = B6, 6 = BE, 7 = E0, 8 = FE, 9 = F6.
  - L = 1C, E = 9E, n = 2A, d = 7A, blank = 00.
  - dp is always 0.
- Lives display: n_lifes is shown directly (0..7). Zero lives displays '0' unless game_over is high.

Decomposition:
- Package hud_pkg holds:
  - the seg_e enum of all 8-bit encodings above;
  - the hud_state_e enum {NORMAL, BLINK, OVER};
  - a function digit_to_seg(4-bit) that returns BLANK for values above 9.
- Sub-module bin_to_bcd_seq handles the conversion.
  - Ports: clk, rst, start, bin[6:0], busy, done, tens[3:0], ones[3:0].
  - 7-cycle iterative conversion.
  - Unit-testable alone.

Test Plan:
Common bench parameters: clk_mhz=1, refresh_hz=250000 (dwell = 4), blink_hz=50000 (half-period = 10), blink_toggles=4.
- Reset/scan: release rst with score=0, n_lifes=3. Required response:
  - Outputs stay 0 for 4 cycles.
  - Then digit sequences 0100(3=F2), 0010(blank 00), 0001(0=FC), 1000(L=1C), 4 cycles each, wrapping.
- BCD: score 0→57. Required response:
  - Tens/ones still show 0 for 7 cycles.
  - Within the next scan, index 2 = B6 and index 3 = E0.
  - score=150 displays 99 (F6, F6).
- Back-to-back change: score 12 → 34 one cycle later. Required response: the final display is 3 and 4 (F2, 66), with no stuck 12.
- Blink: life_lost pulse with n_lifes=2. Required response:
  - Index 1 blank for cycles 0–9, DA for 10–19, blank for 20–29, DA for 30–39.
  - NORMAL resumes at cycle 40.
  - A second pulse at cycle 25 restarts the 40-cycle window.
- Game over: game_over=1 together with life_lost. Required response:
  - FSM = OVER (no blink); display shows 9E, 2A, 7A, 00.
  - Dropping game_over restores the score/lives display.
- Reset mid-operation: rst asserted during BLINK and during conversion. Required response: the next cycle shows all reset values, and BCD = 0.

Source files
------------

// File: rtl/hud_pkg.sv
// Shared segment encodings, display FSM states and the digit-to-segment lookup for the HUD.
package hud_pkg;

   typedef enum logic [7:0] {
      SEG_BLANK = 8'h00,
      SEG_0     = 8'hFC,
      SEG_1     = 8'h60,
      SEG_2     = 8'hDA,
      SEG_3     = 8'hF2,
      SEG_4     = 8'h66,
      SEG_5     = 8'hB6,
      SEG_6     = 8'hBE,
      SEG_7     = 8'hE0,
      SEG_8     = 8'hFE,
      SEG_9     = 8'hF6,
      SEG_L     = 8'h1C,
      SEG_E     = 8'h9E,
      SEG_N     = 8'h2A,
      SEG_D     = 8'h7A
   } seg_e;

   typedef enum logic [1:0] {
      NORMAL,
      BLINK,
      OVER
   } hud_state_e;

   // Anything outside 0..9 renders as an unlit digit.
   function automatic seg_e digit_to_seg(input logic [3:0] v);
      case (v)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary to two-digit BCD for inputs 0..99; done pulses 7 cycles after start.
// A new start is accepted while idle or on the done cycle itself; tens/ones hold until the next done.
module bin_to_bcd_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] bin,
   output logic       busy,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic        busy_q, busy_d;
   logic [2:0]  step_q, step_d;
   logic [6:0]  bin_q, bin_d;
   logic [7:0]  acc_q, acc_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;
   logic [7:0]  adj;
   logic [14:0] shifted;

   always_comb begin
      adj = acc_q;
      if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
      if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
      shifted = {adj, bin_q} << 1;

      done   = busy_q && (step_q == 3'd6);
      busy_d = busy_q;
      step_d = step_q;
      bin_d  = bin_q;
      acc_d  = acc_q;
      tens_d = tens_q;
      ones_d = ones_q;

      if (busy_q) begin
         acc_d  = shifted[14:7];
         bin_d  = shifted[6:0];
         step_d = step_q + 3'd1;
      end
      if (done) begin
         busy_d = 1'b0;
         tens_d = shifted[14:11];
         ones_d = shifted[10:7];
      end
      // Restarting on the done cycle lets back-to-back values stream without a bubble.
      if (start && (!busy_q || done)) begin
         busy_d = 1'b1;
         step_d = 3'd0;
         acc_d  = 8'd0;
         bin_d  = bin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         step_q <= 3'd0;
         bin_q  <= 7'd0;
         acc_q  <= 8'd0;
         tens_q <= 4'd0;
         ones_q <= 4'd0;
      end else begin
         busy_q <= busy_d;
         step_q <= step_d;
         bin_q  <= bin_d;
         acc_q  <= acc_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign busy = busy_q;
   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/seg_hud_driver.sv
// Multiplexes score, lives, a life-lost blink and an "End" screen onto a 4-digit seven-segment display.
// Outputs are registered and change once per dwell period; inputs are sampled every cycle, no backpressure.
module seg_hud_driver
   import hud_pkg::*;
#(
   parameter int clk_mhz       = 50,
   parameter int refresh_hz    = 1000,
   parameter int blink_hz      = 4,
   parameter int blink_toggles = 8,
   parameter int w_score       = 7,
   parameter int w_lifes       = 3,
   parameter int w_digit       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [w_score-1:0] score,
   input  logic [w_lifes-1:0] n_lifes,
   input  logic               life_lost,
   input  logic               game_over,
   output logic [7:0]         abcdefgh,
   output logic [w_digit-1:0] digit
);

   localparam int unsigned DWELL = clk_mhz * 1_000_000 / refresh_hz;
   localparam int unsigned HALF  = clk_mhz * 1_000_000 / (2 * blink_hz);
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int TW = $clog2(blink_toggles + 1);

   if (w_digit != 4) begin : g_digit_check
      $error("seg_hud_driver drives exactly 4 digits");
   end

   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    scan_q, scan_d, scan_nxt;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    dig_q, dig_d;
   logic          tick;
   seg_e          seg_nxt;

   hud_state_e    state_q, state_d;
   logic [HW-1:0] half_q, half_d;
   logic [TW-1:0] tog_q, tog_d;
   logic          phase_q, phase_d;

   logic [6:0]    sat_score, cap_q, cap_d;
   logic          conv_start, conv_busy, conv_done;
   logic [3:0]    tens, ones;

   // Converter only sees 0..99; a new value is latched whenever it can take one.
   always_comb begin
      sat_score  = (int'(score) > 99) ? 7'd99 : 7'(score);
      conv_start = (sat_score != cap_q) && (!conv_busy || conv_done);
      cap_d      = conv_start ? sat_score : cap_q;
   end

   bin_to_bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (sat_score),
      .busy  (conv_busy),
      .done  (conv_done),
      .tens  (tens),
      .ones  (ones)
   );

   // Pattern for the digit that becomes active on the next tick.
   always_comb begin
      scan_nxt = scan_q + 2'd1;
      seg_nxt  = SEG_BLANK;
      if (state_q == OVER) begin
         case (scan_nxt)
            2'd0:    seg_nxt = SEG_E;
            2'd1:    seg_nxt = SEG_N;
            2'd2:    seg_nxt = SEG_D;
            default: seg_nxt = SEG_BLANK;
         endcase
      end else begin
         case (scan_nxt)
            2'd0:    seg_nxt = SEG_L;
            2'd1:    seg_nxt = (state_q == BLINK && !phase_q) ? SEG_BLANK
                                                              : digit_to_seg(4'(n_lifes));
            2'd2:    seg_nxt = (tens == 4'd0) ? SEG_BLANK : digit_to_seg(tens);
            default: seg_nxt = digit_to_seg(ones);
         endcase
      end
   end

   always_comb begin
      tick    = (dwell_q == DW'(DWELL - 1));
      dwell_d = tick ? '0 : dwell_q + DW'(1);
      scan_d  = scan_q;
      seg_d   = seg_q;
      dig_d   = dig_q;
      if (tick) begin
         scan_d = scan_nxt;
         seg_d  = seg_nxt;
         case (scan_nxt)
            2'd0:    dig_d = 4'b1000;
            2'd1:    dig_d = 4'b0100;
            2'd2:    dig_d = 4'b0010;
            default: dig_d = 4'b0001;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      tog_d   = tog_q;
      phase_d = phase_q;
      case (state_q)
         NORMAL: begin
            if (life_lost) begin
               state_d = BLINK;
               half_d  = '0;
               tog_d   = TW'(blink_toggles);
               phase_d = 1'b0;
            end
         end
         BLINK: begin
            if (life_lost) begin
               half_d  = '0;
               tog_d   = TW'(blink_toggles);
               phase_d = 1'b0;
            end else if (half_q == HW'(HALF - 1)) begin
               half_d  = '0;
               phase_d = ~phase_q;
               tog_d   = tog_q - TW'(1);
               if (tog_q == TW'(1)) state_d = NORMAL;
            end else begin
               half_d = half_q + HW'(1);
            end
         end
         default: begin
            state_d = NORMAL;
            half_d  = '0;
            tog_d   = '0;
            phase_d = 1'b0;
         end
      endcase
      // game_over wins over everything, including a same-cycle life_lost.
      if (game_over) begin
         state_d = OVER;
         half_d  = '0;
         tog_d   = '0;
         phase_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q <= '0;
         scan_q  <= 2'd0;
         seg_q   <= 8'd0;
         dig_q   <= 4'd0;
         state_q <= NORMAL;
         half_q  <= '0;
         tog_q   <= '0;
         phase_q <= 1'b0;
         cap_q   <= 7'd0;
      end else begin
         dwell_q <= dwell_d;
         scan_q  <= scan_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         state_q <= state_d;
         half_q  <= half_d;
         tog_q   <= tog_d;
         phase_q <= phase_d;
         cap_q   <= cap_d;
      end
   end

   assign abcdefgh = seg_q;
   assign digit    = dig_q;

endmodule

// File: tb/tb_seg_hud_driver.sv
// Bench for seg_hud_driver: directed scan/table/corner sequences plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_seg_hud_driver;

   localparam int DWELL   = 4;
   localparam int HALF    = 10;
   localparam int TOGGLES = 4;
   localparam int M_NORMAL = 0, M_BLINK = 1, M_OVER = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] score;
   logic [2:0] n_lifes;
   logic       life_lost;
   logic       game_over;
   logic [7:0] abcdefgh;
   logic [3:0] digit;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg_hud_driver #(
      .clk_mhz       (1),
      .refresh_hz    (250000),
      .blink_hz      (50000),
      .blink_toggles (TOGGLES),
      .w_score       (7),
      .w_lifes       (3),
      .w_digit       (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .score     (score),
      .n_lifes   (n_lifes),
      .life_lost (life_lost),
      .game_over (game_over),
      .abcdefgh  (abcdefgh),
      .digit     (digit)
   );

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL %s at %0t: got digit/seg %h required %h", name, $time, got, exp_v);
      end
   endtask

   function automatic logic [7:0] seg_of(input int v);
      case (v)
         0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
         4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
         8: return 8'hFE;  9: return 8'hF6;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------- behavioural reference model ----------------
   logic       s_rst, s_life_lost, s_game_over;
   logic [6:0] s_score;
   logic [2:0] s_lifes;
   always @(posedge clk) begin
      s_rst       <= rst;
      s_score     <= score;
      s_lifes     <= n_lifes;
      s_life_lost <= life_lost;
      s_game_over <= game_over;
   end

   int         m_t, m_cyc, m_shown, m_cap, m_inflight, m_land, m_state, m_age;
   bit         m_busy, m_valid;
   logic [7:0] m_seg;
   logic [3:0] m_dig;

   function automatic logic [7:0] m_content(input int idx);
      if (m_state == M_OVER) begin
         case (idx)
            0: return 8'h9E;
            1: return 8'h2A;
            2: return 8'h7A;
            default: return 8'h00;
         endcase
      end
      case (idx)
         0: return 8'h1C;
         1: return (m_state == M_BLINK && ((m_age / HALF) % 2) == 0) ? 8'h00 : seg_of(int'(s_lifes));
         2: return (m_shown / 10 == 0) ? 8'h00 : seg_of(m_shown / 10);
         default: return seg_of(m_shown % 10);
      endcase
   endfunction

   task automatic model_step();
      int sat;
      int k;
      bit idle;
      sat = (int'(s_score) > 99) ? 99 : int'(s_score);
      if (m_t % DWELL == DWELL - 1) begin
         k     = ((m_t + 1) / DWELL) % 4;
         m_dig = 4'b1000 >> k;
         m_seg = m_content(k);
      end
      m_t++;
      idle = !m_busy || (m_cyc == m_land);
      if (m_busy && m_cyc == m_land) begin
         m_shown = m_inflight;
         m_busy  = 0;
      end
      if (idle && sat != m_cap) begin
         m_cap      = sat;
         m_inflight = sat;
         m_land     = m_cyc + 7;
         m_busy     = 1;
      end
      m_cyc++;
      if (s_game_over) m_state = M_OVER;
      else if (m_state == M_OVER) m_state = M_NORMAL;
      else if (s_life_lost) begin
         m_state = M_BLINK;
         m_age   = 0;
      end else if (m_state == M_BLINK) begin
         m_age++;
         if (m_age == TOGGLES * HALF) m_state = M_NORMAL;
      end
   endtask

   initial begin
      m_valid = 0;
      forever begin
         @(negedge clk);
         if (s_rst === 1'b1) begin
            m_t = 0; m_cyc = 0; m_shown = 0; m_cap = 0; m_inflight = 0; m_land = 0;
            m_state = M_NORMAL; m_age = 0; m_busy = 0;
            m_seg = 8'h00; m_dig = 4'h0; m_valid = 1;
         end else if (m_valid) begin
            model_step();
         end
         if (m_valid) check("model", {digit, abcdefgh}, {m_dig, m_seg});
      end
   end

   // ---------------- directed helpers ----------------
   task automatic scan_check(input string name, input logic [31:0] exp_seg);
      logic [8:0] got [4];
      for (int i = 0; i < 4; i++) got[i] = 9'h1FF;
      repeat (4 * DWELL) begin
         @(negedge clk);
         case (digit)
            4'b1000: got[0] = {1'b0, abcdefgh};
            4'b0100: got[1] = {1'b0, abcdefgh};
            4'b0010: got[2] = {1'b0, abcdefgh};
            4'b0001: got[3] = {1'b0, abcdefgh};
            default: ;
         endcase
      end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] e;
         e = exp_seg[31 - 8 * i -: 8];
         checks++;
         if (got[i] !== {1'b0, e}) begin
            failures++;
            $display("FAIL %s idx%0d: got %h required %h", name, i, got[i], e);
         end
      end
   endtask

   typedef struct {
      logic [6:0]  score;
      logic [2:0]  lives;
      logic        go;
      logic [31:0] exp_seg;
   } vec_t;

   vec_t       vecs [10];
   logic [11:0] scan_seq [5];

   initial begin
      vecs[0] = '{7'd0,   3'd3, 1'b0, 32'h1CF200FC};
      vecs[1] = '{7'd57,  3'd2, 1'b0, 32'h1CDAB6E0};
      vecs[2] = '{7'd127, 3'd7, 1'b0, 32'h1CE0F6F6};
      vecs[3] = '{7'd9,   3'd0, 1'b0, 32'h1CFC00F6};
      vecs[4] = '{7'd10,  3'd5, 1'b0, 32'h1CB660FC};
      vecs[5] = '{7'd99,  3'd1, 1'b1, 32'h9E2A7A00};
      vecs[6] = '{7'd42,  3'd4, 1'b0, 32'h1C6666DA};
      vecs[7] = '{7'd100, 3'd6, 1'b0, 32'h1CBEF6F6};
      vecs[8] = '{7'd8,   3'd1, 1'b0, 32'h1C6000FE};
      vecs[9] = '{7'd70,  3'd3, 1'b0, 32'h1CF2E0FC};
      scan_seq[0] = {4'b0100, 8'hF2};
      scan_seq[1] = {4'b0010, 8'h00};
      scan_seq[2] = {4'b0001, 8'hFC};
      scan_seq[3] = {4'b1000, 8'h1C};
      scan_seq[4] = {4'b0100, 8'hF2};

      rst = 1'b1; score = 7'd0; n_lifes = 3'd3; life_lost = 1'b0; game_over = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", {digit, abcdefgh}, 12'h000);
      rst = 1'b0;

      // Scan order and first-tick latency after reset release.
      for (int j = 1; j < 24; j++) begin
         @(negedge clk);
         check($sformatf("scan_c%0d", j), {digit, abcdefgh},
               (j < DWELL) ? 12'h000 : scan_seq[(j - DWELL) / DWELL]);
      end

      for (int k = 0; k < 10; k++) begin
         score = vecs[k].score; n_lifes = vecs[k].lives; game_over = vecs[k].go;
         repeat (24) @(negedge clk);
         scan_check($sformatf("vec%0d", k), vecs[k].exp_seg);
      end

      // Back-to-back score change must converge on the last value.
      n_lifes = 3'd4; score = 7'd12;
      @(negedge clk);
      score = 7'd34;
      repeat (24) @(negedge clk);
      scan_check("b2b", 32'h1C66F266);

      // Blink with a restart partway through.
      n_lifes = 3'd2; life_lost = 1'b1;
      @(negedge clk);
      life_lost = 1'b0;
      repeat (24) @(negedge clk);
      life_lost = 1'b1;
      @(negedge clk);
      life_lost = 1'b0;
      repeat (60) @(negedge clk);
      scan_check("blink_end", 32'h1CDAF266);

      // Game over beats a simultaneous life_lost.
      game_over = 1'b1; life_lost = 1'b1;
      @(negedge clk);
      life_lost = 1'b0;
      repeat (8) @(negedge clk);
      scan_check("over", 32'h9E2A7A00);
      game_over = 1'b0;
      repeat (8) @(negedge clk);
      scan_check("over_exit", 32'h1CDAF266);

      // Reset during blink.
      life_lost = 1'b1;
      @(negedge clk);
      life_lost = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_blink", {digit, abcdefgh}, 12'h000);
      rst = 1'b0;
      repeat (16) @(negedge clk);
      scan_check("after_rst_blink", 32'h1CDAF266);

      // Reset during conversion leaves BCD at zero.
      score = 7'd57;
      repeat (3) @(negedge clk);
      rst = 1'b1; score = 7'd0;
      @(negedge clk);
      check("rst_conv", {digit, abcdefgh}, 12'h000);
      rst = 1'b0;
      repeat (16) @(negedge clk);
      scan_check("after_rst_conv", 32'h1CDA00FC);

      // Random traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         life_lost = 1'b0;
         rst       = 1'b0;
         if ($urandom_range(0, 19) == 0)  score = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 49) == 0)  n_lifes = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 119) == 0) life_lost = 1'b1;
         if ($urandom_range(0, 299) == 0) game_over = ~game_over;
         if ($urandom_range(0, 799) == 0) rst = 1'b1;
      end
      rst = 1'b0; life_lost = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
